chimera_clu_iso_seq: RTL

CHIMERA_CLU_ISO_SEQ -- requirements
Module: chimera_clu_iso_seq

---
 rtl/chimera_clu_iso_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/chimera_clu_iso_seq.sv
// Cluster power sequencer: isolate, gate clock, assert reset on power-down, and reverse on power-up.
// Optional isolate-handshake timeout: define CHIMERA_ISO_TIMEOUT_EN.
module chimera_clu_iso_seq #(
  parameter bit          BootOn        = 1'b1,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned RstCycles     = 16,
  parameter int unsigned SettleCycles  = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_off_i,
  input  logic       req_on_i,
  input  logic       isolated_i,
  output logic       isolate_o,
  output logic       clu_clk_en_o,
  output logic       clu_rst_no,
  output logic       busy_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  localparam int unsigned CntW = 16;

  typedef enum logic [2:0] {
    ACTIVE     = 3'd0,
    ISO_WAIT   = 3'd1,
    SETTLE_OFF = 3'd2,
    OFF        = 3'd3,
    CLK_ON     = 3'd4,
    RST        = 3'd5,
    DEISO_WAIT = 3'd6,
    FAIL       = 3'd7
  } state_e;

  localparam state_e ResetState = BootOn ? ACTIVE : OFF;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            isolate_q, clk_en_q, rst_n_q, busy_q;
  logic [3:0]      outs_d;

  // Counter value loaded on entry: dwell-1 so the state lasts exactly the dwell.
  function automatic logic [CntW-1:0] entry_load(input state_e s);
    unique case (s)
      ISO_WAIT, DEISO_WAIT: entry_load = CntW'(TimeoutCycles - 1);
      SETTLE_OFF, CLK_ON:   entry_load = CntW'(SettleCycles - 1);
      RST:                  entry_load = CntW'(RstCycles - 1);
      default:              entry_load = '0;
    endcase
  endfunction

  // Moore decode: {isolate, clk_en, rst_n, busy}.
  function automatic logic [3:0] state_outs(input state_e s);
    unique case (s)
      ACTIVE:     state_outs = 4'b0110;
      ISO_WAIT:   state_outs = 4'b1111;
      SETTLE_OFF: state_outs = 4'b1011;
      OFF:        state_outs = 4'b1000;
      CLK_ON:     state_outs = 4'b1101;
      RST:        state_outs = 4'b1101;
      DEISO_WAIT: state_outs = 4'b0111;
      default:    state_outs = 4'b1110;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    cnt_d     = (cnt_q == '0) ? '0 : cnt_q - CntW'(1);
    unique case (state_q)
      ACTIVE:     if (req_off_i && !req_on_i) state_d = ISO_WAIT;
      ISO_WAIT: begin
        if (isolated_i) state_d = SETTLE_OFF;
`ifdef CHIMERA_ISO_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d   = FAIL;
          timeout_d = 1'b1;
        end
`endif
      end
      SETTLE_OFF: if (cnt_q == '0) state_d = OFF;
      OFF:        if (req_on_i && !req_off_i) state_d = CLK_ON;
      CLK_ON:     if (cnt_q == '0) state_d = RST;
      RST:        if (cnt_q == '0) state_d = DEISO_WAIT;
      DEISO_WAIT: begin
        if (!isolated_i) state_d = ACTIVE;
`ifdef CHIMERA_ISO_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d   = FAIL;
          timeout_d = 1'b1;
        end
`endif
      end
      FAIL:       if (req_on_i && !req_off_i) state_d = DEISO_WAIT;
      default:    state_d = ResetState;
    endcase
    if (state_d != state_q) cnt_d = entry_load(state_d);
    outs_d = state_outs(state_d);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q                                   <= ResetState;
      cnt_q                                     <= '0;
      timeout_q                                 <= 1'b0;
      {isolate_q, clk_en_q, rst_n_q, busy_q}    <= state_outs(ResetState);
    end else begin
      state_q                                   <= state_d;
      cnt_q                                     <= cnt_d;
      timeout_q                                 <= timeout_d;
      {isolate_q, clk_en_q, rst_n_q, busy_q}    <= outs_d;
    end
  end

  assign isolate_o    = isolate_q;
  assign clu_clk_en_o = clk_en_q;
  assign clu_rst_no   = rst_n_q;
  assign busy_o       = busy_q;
  assign state_o      = state_q;
`ifdef CHIMERA_ISO_TIMEOUT_EN
  assign timeout_o    = timeout_q;
`else
  assign timeout_o    = 1'b0;
`endif

endmodule
